rf_sequencer: RTL and testbench

RF_SEQUENCER -- requirements
Module: rf_sequencer

---
 rtl/rf_sequencer.sv | 177 +++++++++++++++++
 tb/tb_rf_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_sequencer.sv
// rf_sequencer: four-state instruction sequencer driving a two-entry, 4-bit
// register file. Each accepted instruction runs READ -> EXEC -> WRITE,
// which gives one instruction per 4 cycles.
// Operands are captured before WRITE, so a destination may also be a source.
module rf_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [9:0] instr,
  output logic       rf_sa,
  output logic       rf_sb,
  input  logic [3:0] rf_a,
  input  logic [3:0] rf_b,
  output logic       rf_da,
  output logic       rf_w,
  output logic [3:0] rf_d,
  output logic       busy,
  output logic       done,
  output logic       carry,
  output logic       zero,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t     state_q;
  logic [9:0] instr_q;
  logic [3:0] opa_q;
  logic [3:0] opb_q;
  logic [3:0] rf_d_q;
  logic       rf_w_q;
  logic       ready_q;
  logic       busy_q;
  logic       done_q;
  logic       carry_q;
  logic       zero_q;
  logic       err_q;

  // Next-state values for the result and flags, applied at the EXEC->WRITE edge
  logic [3:0] res_d;
  logic [4:0] sum_d;
  logic       wr_d;
  logic       carry_d;
  logic       zero_d;
  logic       err_d;

  // Decode the latched opcode against the captured operands
  always_comb begin
    res_d   = 4'd0;
    sum_d   = 5'd0;
    wr_d    = 1'b0;
    carry_d = carry_q;
    err_d   = err_q;
    case (instr_q[9:7])
      3'b000: begin
        wr_d = 1'b0;
      end
      3'b001: begin
        res_d = instr_q[3:0];
        wr_d  = 1'b1;
      end
      3'b010: begin
        res_d = opa_q;
        wr_d  = 1'b1;
      end
      3'b011: begin
        sum_d   = {1'b0, opa_q} + {1'b0, opb_q};
        res_d   = sum_d[3:0];
        carry_d = sum_d[4];
        wr_d    = 1'b1;
      end
      3'b100: begin
        res_d   = opa_q - opb_q;
        carry_d = (opa_q < opb_q);
        wr_d    = 1'b1;
      end
      3'b101: begin
        res_d = opa_q & opb_q;
        wr_d  = 1'b1;
      end
      3'b110: begin
        res_d = opa_q ^ opb_q;
        wr_d  = 1'b1;
      end
      default: begin
        err_d = 1'b1;
      end
    endcase
    if (wr_d) begin
      zero_d = (res_d == 4'd0);
    end else begin
      zero_d = zero_q;
    end
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      instr_q <= 10'd0;
      opa_q   <= 4'd0;
      opb_q   <= 4'd0;
      rf_d_q  <= 4'd0;
      rf_w_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          rf_w_q <= 1'b0;
          done_q <= 1'b0;
          if (instr_valid && ready_q) begin
            instr_q <= instr;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          opa_q   <= rf_a;
          opb_q   <= rf_b;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          carry_q <= carry_d;
          zero_q  <= zero_d;
          err_q   <= err_d;
          rf_w_q  <= wr_d;
          done_q  <= 1'b1;
          if (wr_d) begin
            rf_d_q <= res_d;
          end
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          rf_w_q  <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          rf_w_q  <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Selects and write address come straight from the latched instruction
  assign rf_sa       = instr_q[5];
  assign rf_sb       = instr_q[4];
  assign rf_da       = instr_q[6];
  assign rf_d        = rf_d_q;
  assign rf_w        = rf_w_q;
  assign instr_ready = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign carry       = carry_q;
  assign zero        = zero_q;
  assign err         = err_q;

endmodule

// File: tb/tb_rf_sequencer.sv
// Bench for rf_sequencer: directed and random instructions against a
// behavioural model holding register contents and flags.
module tb_rf_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [9:0] instr;
  logic       rf_sa, rf_sb, rf_da, rf_w;
  logic [3:0] rf_a, rf_b, rf_d;
  logic       busy, done, carry, zero, err;

  int checks   = 0;
  int failures = 0;

  // Register file seen by the DUT
  logic [3:0] rf_env [2] = '{4'd0, 4'd0};
  // Reference model state
  logic [3:0] m_reg [2] = '{4'd0, 4'd0};
  logic       m_carry = 1'b0;
  logic       m_zero  = 1'b0;
  logic       m_err   = 1'b0;

  rf_sequencer dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rf_sa(rf_sa), .rf_sb(rf_sb), .rf_a(rf_a), .rf_b(rf_b),
    .rf_da(rf_da), .rf_w(rf_w), .rf_d(rf_d), .busy(busy), .done(done),
    .carry(carry), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  // Combinational read ports and clocked write port of the register file
  assign rf_a = rf_env[rf_sa];
  assign rf_b = rf_env[rf_sb];
  always @(posedge clk) if (rf_w) rf_env[rf_da] <= rf_d;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Architectural effect of one instruction, using plain integer arithmetic
  task automatic model_step(input logic [9:0] ins, output logic w, output logic [3:0] d);
    int a, b, r;
    a = int'(m_reg[ins[5]]);
    b = int'(m_reg[ins[4]]);
    r = 0;
    w = 1'b0;
    m_err = 1'b0;
    case (int'(ins[9:7]))
      1: begin r = int'(ins[3:0]); w = 1'b1; end
      2: begin r = a; w = 1'b1; end
      3: begin r = (a + b) % 16; m_carry = ((a + b) > 15); w = 1'b1; end
      4: begin r = (a - b + 16) % 16; m_carry = (a < b); w = 1'b1; end
      5: begin r = a & b; w = 1'b1; end
      6: begin r = a ^ b; w = 1'b1; end
      7: m_err = 1'b1;
      default: ;
    endcase
    d = r[3:0];
    if (w) begin
      m_zero = (r == 0);
      m_reg[ins[6]] = d;
    end
  endtask

  // Offer one instruction, then check every phase of its execution
  task automatic run_instr(input logic [9:0] ins);
    logic w;
    logic [3:0] d;
    logic c0, z0;
    int n;
    @(negedge clk);
    n = 0;
    while (!instr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk1("ready_before_accept", instr_ready, 1'b1);
    instr_valid = 1'b1;
    instr = ins;
    c0 = m_carry;
    z0 = m_zero;
    model_step(ins, w, d);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = 10'($urandom);
    @(negedge clk);
    chk1("read_ready", instr_ready, 1'b0);
    chk1("read_busy", busy, 1'b1);
    chk1("read_rf_w", rf_w, 1'b0);
    chk1("read_done", done, 1'b0);
    chk1("read_sa", rf_sa, ins[5]);
    chk1("read_sb", rf_sb, ins[4]);
    chk1("read_err", err, 1'b0);
    chk1("read_carry", carry, c0);
    chk1("read_zero", zero, z0);
    @(negedge clk);
    chk1("exec_rf_w", rf_w, 1'b0);
    chk1("exec_done", done, 1'b0);
    chk1("exec_busy", busy, 1'b1);
    @(negedge clk);
    chk1("write_rf_w", rf_w, w);
    chk1("write_done", done, 1'b1);
    chk1("write_busy", busy, 1'b1);
    chk1("write_carry", carry, m_carry);
    chk1("write_zero", zero, m_zero);
    chk1("write_err", err, m_err);
    chk1("write_sa", rf_sa, ins[5]);
    if (w) begin
      chk1("write_da", rf_da, ins[6]);
      chk4("write_d", rf_d, d);
    end
    @(negedge clk);
    chk1("idle_rf_w", rf_w, 1'b0);
    chk1("idle_done", done, 1'b0);
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_ready", instr_ready, 1'b1);
    chk1("idle_err", err, m_err);
  endtask

  initial begin
    logic [9:0] q [3];
    logic       hw;
    logic [3:0] hd;
    int         wcount;

    rst = 1'b1;
    instr_valid = 1'b0;
    instr = 10'd0;
    #12;
    chk1("rst_rf_w", rf_w, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_carry", carry, 1'b0);
    chk1("rst_zero", zero, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk4("rst_rf_d", rf_d, 4'd0);
    chk1("rst_rf_da", rf_da, 1'b0);
    chk1("rst_rf_sa", rf_sa, 1'b0);
    chk1("rst_rf_sb", rf_sb, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("post_rst_ready", instr_ready, 1'b1);

    // Directed arithmetic cases
    run_instr(10'b001_0_0_0_1001);  // LDI R0=9
    run_instr(10'b001_1_0_0_1000);  // LDI R1=8
    run_instr(10'b011_1_0_1_0000);  // ADD R1=R0+R1 -> 1, carry
    run_instr(10'b001_0_0_0_0011);  // LDI R0=3
    run_instr(10'b100_0_0_0_0000);  // SUB R0=R0-R0 -> 0, zero
    run_instr(10'b001_0_0_0_0010);  // LDI R0=2
    run_instr(10'b001_1_0_0_0101);  // LDI R1=5
    run_instr(10'b100_0_0_1_0000);  // SUB R0=2-5 -> 13, borrow
    run_instr(10'b111_0_0_0_0000);  // illegal -> err
    @(negedge clk);
    chk1("err_sticky", err, 1'b1);
    run_instr(10'b001_1_0_0_0000);  // LDI clears err

    // Back-to-back acceptance with instr_valid held high
    q[0] = 10'b001_1_0_0_0111;      // LDI R1=7
    q[1] = 10'b011_0_1_1_0000;      // ADD R0=R1+R1 -> 14
    q[2] = 10'b110_1_0_1_0000;      // XOR R1=R0^R1 -> 9
    wcount = 0;
    hw = 1'b0;
    hd = 4'd0;
    @(negedge clk);
    instr_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      chk1("stream_ready", instr_ready, logic'(c % 4 == 0));
      chk1("stream_busy", busy, logic'(c % 4 != 0));
      if (c % 4 == 0) begin
        instr = q[c / 4];
        model_step(q[c / 4], hw, hd);
      end
      if (rf_w) wcount++;
      if (c % 4 == 3) begin
        chk1("stream_rf_w", rf_w, hw);
        chk4("stream_rf_d", rf_d, hd);
        chk1("stream_done", done, 1'b1);
      end
      if (c == 11) instr_valid = 1'b0;
    end
    @(negedge clk);
    chk1("stream_end_ready", instr_ready, 1'b1);
    chk4("stream_writes", 4'(wcount), 4'd3);

    // Reset during EXEC of an ADD aborts it
    @(negedge clk);
    instr_valid = 1'b1;
    instr = 10'b011_0_0_1_0000;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk1("abort_rf_w", rf_w, 1'b0);
    chk1("abort_done", done, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_carry", carry, 1'b0);
    chk1("abort_zero", zero, 1'b0);
    chk1("abort_err", err, 1'b0);
    chk4("abort_rf_d", rf_d, 4'd0);
    m_carry = 1'b0;
    m_zero  = 1'b0;
    m_err   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("release_ready", instr_ready, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1("after_abort_rf_w", rf_w, 1'b0);
      chk1("after_abort_done", done, 1'b0);
    end
    run_instr(10'b010_1_0_0_0000);  // MOV R1=R0 shows the register file untouched

    // Randomized instructions against the model
    for (int k = 0; k < 40; k++) begin
      run_instr(10'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
